// File: rtl/cntry_vehicle_detector.sv
// Country-road vehicle detector: synchronizes and debounces an inductive loop into
// car arrivals, keeps a saturating queue count, and drains it while country is GREEN.
module cntry_vehicle_detector #(
    parameter int unsigned DEBOUNCE    = 3,
    parameter int unsigned PASS_CYCLES = 2,
    parameter int unsigned QW          = 4
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          loop_raw,
    input  logic [1:0]    cntry,
    output logic          X,
    output logic [QW-1:0] queue_cnt,
    output logic          arrival_pulse,
    output logic          overflow
);

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        OCCUPIED,
        RELEASING
    } state_t;

    localparam logic [3:0]    DEB_LAST  = 4'(DEBOUNCE - 1);
    localparam logic [3:0]    PASS_LAST = 4'(PASS_CYCLES - 1);
    localparam logic [QW-1:0] Q_MAX     = '1;
    localparam logic [1:0]    GREEN     = 2'd2;

    state_t       state;
    state_t       state_nxt;
    logic [3:0]   deb_cnt;
    logic [3:0]   deb_nxt;
    logic [3:0]   dep_cnt;
    logic [3:0]   dep_nxt;
    logic         sync_1;
    logic         s;
    logic         arrival;
    logic         departure;
    logic         green_busy;

    // Two-flop synchronizer; only s is visible to the debounce logic.
    always_ff @(posedge clock) begin
        if (!clear) begin
            sync_1 <= 1'b0;
            s      <= 1'b0;
        end else begin
            sync_1 <= loop_raw;
            s      <= sync_1;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state   <= IDLE;
            deb_cnt <= '0;
        end else begin
            state   <= state_nxt;
            deb_cnt <= deb_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        arrival   = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    if (DEBOUNCE == 1) begin
                        state_nxt = OCCUPIED;
                        deb_nxt   = '0;
                        arrival   = 1'b1;
                    end else begin
                        state_nxt = ARMING;
                        deb_nxt   = 4'd1;
                    end
                end
            end
            ARMING: begin
                if (!s) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = OCCUPIED;
                    deb_nxt   = '0;
                    arrival   = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + 4'd1;
                end
            end
            OCCUPIED: begin
                if (!s) begin
                    if (DEBOUNCE == 1) begin
                        state_nxt = IDLE;
                        deb_nxt   = '0;
                    end else begin
                        state_nxt = RELEASING;
                        deb_nxt   = 4'd1;
                    end
                end
            end
            RELEASING: begin
                if (s) begin
                    state_nxt = OCCUPIED;
                    deb_nxt   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                end else begin
                    deb_nxt = deb_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                deb_nxt   = '0;
            end
        endcase
    end

    // A pass only progresses while GREEN with cars queued; otherwise it restarts.
    always_comb begin
        green_busy = (cntry == GREEN) && (queue_cnt != '0);
        departure  = green_busy && (dep_cnt == PASS_LAST);
        dep_nxt    = (green_busy && !departure) ? dep_cnt + 4'd1 : '0;
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            dep_cnt       <= '0;
            queue_cnt     <= '0;
            arrival_pulse <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            dep_cnt       <= dep_nxt;
            arrival_pulse <= arrival;
            case ({arrival, departure})
                2'b10: begin
                    if (queue_cnt == Q_MAX) begin
                        overflow <= 1'b1;
                    end else begin
                        queue_cnt <= queue_cnt + 1'b1;
                    end
                end
                2'b01:   queue_cnt <= queue_cnt - 1'b1;
                default: queue_cnt <= queue_cnt;
            endcase
        end
    end

    assign X = |queue_cnt;

endmodule

// File: tb/tb_cntry_vehicle_detector.sv
// Bench for cntry_vehicle_detector: two parameterisations driven in parallel and
// compared every cycle against a run-length based behavioural model.
module tb_cntry_vehicle_detector;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       loop_raw = 1'b0;
    logic [1:0] cntry = 2'd0;

    logic       x_0, pulse_0, ovf_0;
    logic [3:0] q_0;
    logic       x_1, pulse_1, ovf_1;
    logic [1:0] q_1;

    int checks = 0;
    int errors = 0;

    // Per-instance model constants: instance 0 default, instance 1 small/saturating.
    int deb_k [2] = '{3, 1};
    int pass_k[2] = '{2, 3};
    int max_k [2] = '{15, 3};

    int m_s1 [2];
    int m_s2 [2];
    int m_lvl[2];
    int m_run[2];
    int m_grn[2];
    int m_q  [2];
    int m_ovf[2];
    int m_pul[2];

    always #5 clock = ~clock;

    cntry_vehicle_detector #(.DEBOUNCE(3), .PASS_CYCLES(2), .QW(4)) dut_0 (
        .clock(clock), .clear(clear), .loop_raw(loop_raw), .cntry(cntry),
        .X(x_0), .queue_cnt(q_0), .arrival_pulse(pulse_0), .overflow(ovf_0)
    );

    cntry_vehicle_detector #(.DEBOUNCE(1), .PASS_CYCLES(3), .QW(2)) dut_1 (
        .clock(clock), .clear(clear), .loop_raw(loop_raw), .cntry(cntry),
        .X(x_1), .queue_cnt(q_1), .arrival_pulse(pulse_1), .overflow(ovf_1)
    );

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Accepted loop level flips after deb_k consecutive differing samples;
    // a car leaves after pass_k consecutive GREEN cycles with a non-empty queue.
    task automatic model_step(input int k, input logic raw, input logic [1:0] cn, input logic clr);
        int a;
        int d;
        if (!clr) begin
            m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_run[k] = 0;
            m_grn[k] = 0; m_q[k] = 0; m_ovf[k] = 0; m_pul[k] = 0;
        end else begin
            a = 0;
            d = 0;
            if (m_s2[k] != m_lvl[k]) begin
                m_run[k]++;
                if (m_run[k] == deb_k[k]) begin
                    m_lvl[k] = m_s2[k];
                    m_run[k] = 0;
                    a = m_lvl[k];
                end
            end else begin
                m_run[k] = 0;
            end
            if (cn == 2'd2 && m_q[k] != 0) begin
                m_grn[k]++;
                if (m_grn[k] == pass_k[k]) begin
                    d = 1;
                    m_grn[k] = 0;
                end
            end else begin
                m_grn[k] = 0;
            end
            if (a == 1 && d == 0) begin
                if (m_q[k] == max_k[k]) m_ovf[k] = 1;
                else m_q[k]++;
            end else if (d == 1 && a == 0) begin
                m_q[k]--;
            end
            m_pul[k] = a;
            m_s2[k] = m_s1[k];
            m_s1[k] = int'(raw);
        end
    endtask

    task automatic compare_all();
        check("x0",     32'(x_0),     (m_q[0] != 0) ? 1 : 0);
        check("q0",     32'(q_0),     m_q[0]);
        check("pulse0", 32'(pulse_0), m_pul[0]);
        check("ovf0",   32'(ovf_0),   m_ovf[0]);
        check("x1",     32'(x_1),     (m_q[1] != 0) ? 1 : 0);
        check("q1",     32'(q_1),     m_q[1]);
        check("pulse1", 32'(pulse_1), m_pul[1]);
        check("ovf1",   32'(ovf_1),   m_ovf[1]);
    endtask

    task automatic cyc(input logic raw, input logic [1:0] cn, input logic clr);
        loop_raw = raw;
        cntry    = cn;
        clear    = clr;
        @(posedge clock);
        for (int k = 0; k < 2; k++) model_step(k, raw, cn, clr);
        #1;
        compare_all();
    endtask

    initial begin
        int hold;
        logic r;
        logic [1:0] c;

        // Reset dominates a present car and a GREEN light.
        repeat (3) cyc(1'b1, 2'd2, 1'b0);
        check("rst_x", 32'(x_0), 0);
        check("rst_q", 32'(q_0), 0);
        check("rst_ovf", 32'(ovf_0), 0);

        // First sampled-high edge after release is E0; arrival lands on E0+4.
        repeat (4) cyc(1'b1, 2'd0, 1'b1);
        check("lat_early", 32'(q_0), 0);
        cyc(1'b1, 2'd0, 1'b1);
        check("lat_q", 32'(q_0), 1);
        check("lat_pulse", 32'(pulse_0), 1);
        check("lat_x", 32'(x_0), 1);

        repeat (50) cyc(1'b1, 2'd0, 1'b1);
        check("parked", 32'(q_0), 1);
        repeat (6) cyc(1'b0, 2'd0, 1'b1);

        repeat (2) cyc(1'b1, 2'd0, 1'b1);
        repeat (6) cyc(1'b0, 2'd0, 1'b1);
        check("glitch", 32'(q_0), 1);

        repeat (2) begin
            repeat (4) cyc(1'b1, 2'd0, 1'b1);
            repeat (6) cyc(1'b0, 2'd0, 1'b1);
        end
        check("three_q", 32'(q_0), 3);
        check("sat_q", 32'(q_1), 3);
        check("sat_ovf", 32'(ovf_1), 1);
        check("no_ovf0", 32'(ovf_0), 0);

        cyc(1'b0, 2'd2, 1'b1);
        cyc(1'b0, 2'd1, 1'b1);
        check("green_drop", 32'(q_0), 3);

        for (int i = 1; i <= 6; i++) begin
            cyc(1'b0, 2'd2, 1'b1);
            if (i % 2 == 0) check("drain_q", 32'(q_0), 3 - i / 2);
            if (i == 5) check("drain_x_hi", 32'(x_0), 1);
        end
        check("drain_x_lo", 32'(x_0), 0);
        repeat (4) cyc(1'b0, 2'd2, 1'b1);
        check("drain_q1", 32'(q_1), 0);
        check("ovf_sticky", 32'(ovf_1), 1);

        // Build q0=2, then align an acceptance with the second departure.
        repeat (2) begin
            repeat (4) cyc(1'b1, 2'd0, 1'b1);
            repeat (6) cyc(1'b0, 2'd0, 1'b1);
        end
        check("pre_simul", 32'(q_0), 2);
        cyc(1'b1, 2'd0, 1'b1);
        repeat (4) cyc(1'b1, 2'd2, 1'b1);
        check("simul_q", 32'(q_0), 1);
        check("simul_pulse", 32'(pulse_0), 1);

        hold = 0;
        r = 1'b0;
        c = 2'd0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                r = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 7));
            end
            hold--;
            if ($urandom_range(0, 5) == 0) c = 2'($urandom_range(0, 3));
            cyc(r, c, ($urandom_range(0, 299) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
